// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the execute-stage operand muxes.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {RUN, BUSY} hctrl_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EXE source register; the MEM result beats the WB result.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              reg_write_mem_i,
  input  logic              reg_write_wb_i,
  output logic [1:0]        fwd_o
);

  always_comb begin
    fwd_o = FWD_NONE;
    // x0 is hardwired to zero, so a write to it must never be forwarded.
    if (reg_write_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: forwarding, load-use stalls, redirect flushes,
// multi-cycle EXE sequencing and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              uses_rs2_ID,
  input  logic [REG_AW-1:0] rs1_EXE,
  input  logic [REG_AW-1:0] rs2_EXE,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic              mem_read_EXE,
  input  logic              mc_op_EXE,
  input  logic              pc_next_sel,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [REG_AW-1:0] rd_WB,
  input  logic              reg_write_MEM,
  input  logic              reg_write_WB,
  output logic [1:0]        forwarding_a,
  output logic [1:0]        forwarding_b,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              stall_EXE,
  output logic              flush_ID,
  output logic              flush_EXE,
  output logic              flush_MEM,
  output logic              mc_done,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Wide enough to hold MC_LATENCY-2, never narrower than one bit.
  localparam int unsigned CntW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;

  hctrl_state_t     state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       luse;
  logic       stall_if_c, stall_id_c, stall_exe_c;
  logic       flush_id_c, flush_exe_c, flush_mem_c, mc_done_c;

  fwd_unit u_fwd_a (
    .rs_i           (rs1_EXE),
    .rd_mem_i       (rd_MEM),
    .rd_wb_i        (rd_WB),
    .reg_write_mem_i(reg_write_MEM),
    .reg_write_wb_i (reg_write_WB),
    .fwd_o          (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_i           (rs2_EXE),
    .rd_mem_i       (rd_MEM),
    .rd_wb_i        (rd_WB),
    .reg_write_mem_i(reg_write_MEM),
    .reg_write_wb_i (reg_write_WB),
    .fwd_o          (fwd_b)
  );

  assign luse = mem_read_EXE && (rd_EXE != '0) &&
                ((rd_EXE == rs1_ID) || (uses_rs2_ID && (rd_EXE == rs2_ID)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    stall_exe_c = 1'b0;
    flush_id_c  = 1'b0;
    flush_exe_c = 1'b0;
    flush_mem_c = 1'b0;
    mc_done_c   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mc_op_EXE) begin
          // First cycle of the op counts as one of its MC_LATENCY EXE cycles.
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          stall_exe_c = 1'b1;
          flush_mem_c = 1'b1;
          cnt_d       = CntW'(MC_LATENCY - 2);
          state_d     = BUSY;
        end else if (pc_next_sel) begin
          flush_id_c  = 1'b1;
          flush_exe_c = 1'b1;
        end else if (luse) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          flush_exe_c = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          stall_exe_c = 1'b1;
          flush_mem_c = 1'b1;
          cnt_d       = cnt_q - CntW'(1);
        end else begin
          mc_done_c = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Every output is forced low while reset is held, including the combinational paths.
  assign forwarding_a = rst ? fwd_a : FWD_NONE;
  assign forwarding_b = rst ? fwd_b : FWD_NONE;
  assign stall_IF     = rst & stall_if_c;
  assign stall_ID     = rst & stall_id_c;
  assign stall_EXE    = rst & stall_exe_c;
  assign flush_ID     = rst & flush_id_c;
  assign flush_EXE    = rst & flush_exe_c;
  assign flush_MEM    = rst & flush_mem_c;
  assign mc_done      = rst & mc_done_c;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_IF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((flush_ID || flush_EXE) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a combinational vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int unsigned MC_LATENCY = 4;
  localparam int unsigned CNT_W      = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1_ID, rs2_ID, rs1_EXE, rs2_EXE, rd_EXE, rd_MEM, rd_WB;
  logic             uses_rs2_ID, mem_read_EXE, mc_op_EXE, pc_next_sel;
  logic             reg_write_MEM, reg_write_WB;
  logic [1:0]       forwarding_a, forwarding_b;
  logic             stall_IF, stall_ID, stall_EXE, flush_ID, flush_EXE, flush_MEM, mc_done;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .MC_LATENCY(MC_LATENCY),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .uses_rs2_ID  (uses_rs2_ID),
    .rs1_EXE      (rs1_EXE),
    .rs2_EXE      (rs2_EXE),
    .rd_EXE       (rd_EXE),
    .mem_read_EXE (mem_read_EXE),
    .mc_op_EXE    (mc_op_EXE),
    .pc_next_sel  (pc_next_sel),
    .rd_MEM       (rd_MEM),
    .rd_WB        (rd_WB),
    .reg_write_MEM(reg_write_MEM),
    .reg_write_WB (reg_write_WB),
    .forwarding_a (forwarding_a),
    .forwarding_b (forwarding_b),
    .stall_IF     (stall_IF),
    .stall_ID     (stall_ID),
    .stall_EXE    (stall_EXE),
    .flush_ID     (flush_ID),
    .flush_EXE    (flush_EXE),
    .flush_MEM    (flush_MEM),
    .mc_done      (mc_done),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // Expected combinational outputs packed as {fa[1:0], fb[1:0], sIF, sID, sEXE, fID, fEXE, fMEM}.
  typedef struct packed {
    logic [4:0] rs1_id, rs2_id;
    logic       u2;
    logic [4:0] rs1_exe, rs2_exe, rd_exe;
    logic       mr, pns;
    logic [4:0] rd_mem, rd_wb;
    logic       rwm, rww;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [4:0] r1i, r2i, input logic u2,
                              input logic [4:0] r1e, r2e, rde, input logic mr, pns,
                              input logic [4:0] rdm, rdw, input logic rwm, rww,
                              input logic [9:0] exp);
    vec_t v;
    v.rs1_id = r1i; v.rs2_id = r2i; v.u2 = u2; v.rs1_exe = r1e; v.rs2_exe = r2e;
    v.rd_exe = rde; v.mr = mr; v.pns = pns; v.rd_mem = rdm; v.rd_wb = rdw;
    v.rwm = rwm; v.rww = rww; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_ID = 0; rs2_ID = 0; uses_rs2_ID = 0; rs1_EXE = 0; rs2_EXE = 0; rd_EXE = 0;
    mem_read_EXE = 0; mc_op_EXE = 0; pc_next_sel = 0; rd_MEM = 0; rd_WB = 0;
    reg_write_MEM = 0; reg_write_WB = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    rs1_ID = v.rs1_id; rs2_ID = v.rs2_id; uses_rs2_ID = v.u2; rs1_EXE = v.rs1_exe;
    rs2_EXE = v.rs2_exe; rd_EXE = v.rd_exe; mem_read_EXE = v.mr; pc_next_sel = v.pns;
    rd_MEM = v.rd_mem; rd_WB = v.rd_wb; reg_write_MEM = v.rwm; reg_write_WB = v.rww;
    mc_op_EXE = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [9:0] comb_out();
    return {forwarding_a, forwarding_b, stall_IF, stall_ID, stall_EXE,
            flush_ID, flush_EXE, flush_MEM};
  endfunction

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b00_00_000000);
    vecs[1]  = mk(0, 0, 0, 5, 0, 0, 0, 0, 5, 5, 1, 1, 10'b10_00_000000);
    vecs[2]  = mk(0, 0, 0, 5, 0, 0, 0, 0, 5, 5, 0, 1, 10'b01_00_000000);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 10'b00_00_000000);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10'b00_00_000000);
    vecs[5]  = mk(0, 0, 0, 3, 9, 0, 0, 0, 3, 9, 1, 1, 10'b10_01_000000);
    vecs[6]  = mk(0, 0, 0, 4, 9, 0, 0, 0, 9, 9, 1, 1, 10'b00_10_000000);
    vecs[7]  = mk(1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 10'b00_00_110010);
    vecs[8]  = mk(1, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 10'b00_00_000000);
    vecs[9]  = mk(7, 2, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 10'b00_00_110010);
    vecs[10] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10'b00_00_000000);
    vecs[11] = mk(7, 7, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 10'b00_00_000000);
    vecs[12] = mk(7, 2, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 10'b00_00_000110);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10'b00_00_000110);

    // Reset held with active inputs: every output must stay low.
    rst = 1'b0;
    idle_inputs();
    rs1_EXE = 5; rd_MEM = 5; reg_write_MEM = 1; mc_op_EXE = 1; pc_next_sel = 1;
    mem_read_EXE = 1; rd_EXE = 7; rs1_ID = 7;
    #3;
    chk("reset_outputs", {comb_out(), mc_done, stall_cnt, flush_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();

    // Combinational table, applied in RUN.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i), comb_out(), vecs[i].exp);
    end

    // Load-use through rs2: one stalled cycle, counted once.
    do_reset();
    apply_vec(vecs[7]);
    #1;
    chk("luse_stall", {stall_IF, stall_ID, flush_EXE}, 3'b111);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("luse_released", {stall_IF, stall_ID, flush_EXE}, 3'b000);
    chk("luse_stall_cnt", stall_cnt, 1);
    apply_vec(vecs[8]);
    @(negedge clk);
    chk("no_rs2_no_stall_cnt", stall_cnt, 1);

    // Redirect beats load-use.
    do_reset();
    apply_vec(vecs[12]);
    #1;
    chk("redir_prio", {flush_ID, flush_EXE, stall_IF, stall_ID}, 4'b1100);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("redir_flush_cnt", flush_cnt, 1);
    chk("redir_stall_cnt", stall_cnt, 0);

    // Single multi-cycle op with a redirect pulse during BUSY.
    do_reset();
    mc_op_EXE = 1;
    #1;
    chk("mc_c1", {stall_IF, stall_ID, stall_EXE, flush_MEM, mc_done}, 5'b11110);
    @(negedge clk);
    pc_next_sel = 1;
    #1;
    chk("mc_c2", {stall_EXE, flush_MEM, mc_done}, 3'b110);
    chk("mc_busy_no_flush", {flush_ID, flush_EXE}, 2'b00);
    @(negedge clk);
    pc_next_sel = 0;
    #1;
    chk("mc_c3", {stall_EXE, mc_done}, 2'b10);
    @(negedge clk);
    #1;
    chk("mc_c4_done", {stall_IF, stall_EXE, flush_MEM, mc_done}, 4'b0001);
    @(negedge clk);
    mc_op_EXE = 0;
    pc_next_sel = 1;
    #1;
    chk("mc_back_in_run", {flush_ID, mc_done, stall_EXE}, 3'b100);
    @(negedge clk);
    idle_inputs();
    chk("mc_stall_cnt", stall_cnt, 3);
    chk("mc_flush_cnt", flush_cnt, 1);

    // Back-to-back ops: level held for two full sequences.
    do_reset();
    mc_op_EXE = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("b2b_c%0d", i), {stall_EXE, mc_done},
          ((i % 4) == 3) ? 2'b01 : 2'b10);
      @(negedge clk);
    end
    idle_inputs();

    // Asynchronous reset in the second BUSY cycle.
    do_reset();
    mc_op_EXE = 1;
    @(negedge clk);
    @(negedge clk);
    rs1_EXE = 5; rd_MEM = 5; reg_write_MEM = 1;
    #1;
    chk("busy2_before_rst", stall_EXE, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {comb_out(), mc_done, stall_cnt, flush_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;
    mc_op_EXE = 0;
    pc_next_sel = 1;
    #1;
    chk("post_rst_run", {flush_ID, stall_EXE, forwarding_a}, 4'b1010);
    chk("post_rst_cnts", {stall_cnt, flush_cnt}, 0);
    @(negedge clk);
    idle_inputs();

    // Saturation of the 4-bit stall counter.
    do_reset();
    apply_vec(vecs[9]);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("sat_mid", stall_cnt, 10);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("sat_full", stall_cnt, 15);
    @(negedge clk);
    @(negedge clk);
    chk("sat_hold", stall_cnt, 15);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Generates the forwarding_a/forwarding_b selects consumed by the execute stage.
- Detects load-use hazards and squashes wrong-path instructions on a branch or jump redirect (pc_next_sel from execute).
- Sequences multi-cycle EXE operations (e.g. divide) with a latency counter that freezes the front of the pipe.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- MC_LATENCY, 4: total cycles a multi-cycle op occupies EXE; legal range is 2 or more.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID
- uses_rs2_ID  in  1  the ID instruction reads rs2
- rs1_EXE, rs2_EXE, rd_EXE  in  5 each  register fields of the instruction in EXE
- mem_read_EXE  in  1  the EXE instruction is a load
- mc_op_EXE  in  1  the EXE instruction is a multi-cycle op (level signal)
- pc_next_sel  in  1  branch taken or jump, resolved in EXE
- rd_MEM, rd_WB  in  5 each  destination registers in MEM and WB
- reg_write_MEM, reg_write_WB  in  1 each  write enables for MEM and WB
- forwarding_a, forwarding_b  out  2 each  operand select: 10 = MEM, 01 = WB, 00 = register file
- stall_IF, stall_ID, stall_EXE  out  1 each  hold the corresponding pipeline register
- flush_ID, flush_EXE, flush_MEM  out  1 each  insert a bubble into the named stage next cycle
- mc_done  out  1  final cycle of a multi-cycle op
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

Behaviour:
- Reset (rst = 0, asynchronous):
  - state goes to RUN; cnt and both performance counters clear to 0.
  - While rst is low, every output is 0.
- Forwarding (combinational):
  - forwarding_a = 10 if reg_write_MEM and rd_MEM != 0 and rd_MEM == rs1_EXE.
  - Otherwise forwarding_a = 01 if reg_write_WB and rd_WB != 0 and rd_WB == rs1_EXE.
  - Otherwise forwarding_a = 00.
  - forwarding_b is the same rule using rs2_EXE.
  - MEM always wins over WB. x0 never forwards.
- Load-use (combinational, RUN state only):
  - luse = mem_read_EXE & rd_EXE != 0 & (rd_EXE == rs1_ID | (uses_rs2_ID & rd_EXE == rs2_ID)).
  - When luse is set: stall_IF = stall_ID = flush_EXE = 1 for exactly one cycle. No FSM state is needed.
- Redirect (RUN state only):
  - pc_next_sel = 1 gives flush_ID = flush_EXE = 1 in the same cycle.
  - Redirect has priority over luse: stalls are 0 and flushes are still asserted.
- FSM with states RUN and BUSY:
  - RUN with mc_op_EXE = 1:
    - stall_IF = stall_ID = stall_EXE = flush_MEM = 1.
    - Load cnt = MC_LATENCY-2.
    - If MC_LATENCY == 2, the next state is BUSY with cnt = 0.
    - Otherwise the next state is BUSY.
  - BUSY with cnt != 0: assert the same four outputs and decrement cnt.
  - BUSY with cnt == 0: no stalls, mc_done = 1, next state RUN. The op leaves EXE this cycle.
  - Resulting timing: the op occupies EXE for MC_LATENCY cycles, of which MC_LATENCY-1 are stalled.
  - In BUSY: pc_next_sel and luse are ignored, and flush_EXE, flush_ID and flush_EXE-by-luse are 0.
  - Back-to-back multi-cycle ops: mc_op_EXE seen in RUN on the cycle after mc_done starts a new sequence.
- Counters:
  - stall_cnt increments each cycle in which stall_IF = 1.
  - flush_cnt increments each cycle in which flush_ID | flush_EXE is set.
  - Both saturate at all-ones.
- Reset mid-BUSY: state returns to RUN immediately and all outputs drop to 0 asynchronously.

Decomposition:
- Shared package hazard_pkg:
  - FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10 (also used by execute).
  - State enum hctrl_state_t {RUN, BUSY}.
- One sub-module, fwd_unit: combinational forwarding select, instantiated once per operand.

Test Plan:
- Forwarding priority: rd_MEM = rd_WB = 5, both write enables on, rs1_EXE = 5 → forwarding_a = 10. Then clear reg_write_MEM → 01. Then set rd_WB = 0 and rs1_EXE = 0 → 00.
- Load-use: mem_read_EXE = 1, rd_EXE = 7, rs2_ID = 7, uses_rs2_ID = 1 → stall_IF, stall_ID and flush_EXE high for exactly 1 cycle; stall_cnt = 1. With uses_rs2_ID = 0 → no stall.
- Redirect priority: pc_next_sel = 1 together with a luse condition → flush_ID = flush_EXE = 1, stall_IF = 0; flush_cnt increments by 1.
- Multi-cycle op, MC_LATENCY = 4: mc_op_EXE held high → stall_EXE high for 3 cycles, mc_done high on the 4th cycle, then RUN. A pc_next_sel pulse during BUSY produces no flush.
- Reset mid-BUSY: drop rst in the 2nd BUSY cycle → all outputs 0 immediately; after release, the FSM is in RUN and the counters read 0.
- Saturation: with CNT_W = 4, hold luse for 20 cycles → stall_cnt = 15 and stays there.
